// File: rtl/sn_ctrl_pkg.sv
// Shared definitions for the stochastic decoder frame sequencer and the node array top.
// Holds the sequencer state encoding and the default frame timing constants.
package sn_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_DECODE = 2'd2,
      ST_DONE   = 2'd3
   } ctrl_state_e;

   localparam int DEF_INIT_CYC = 8;
   localparam int DEF_MAX_DC   = 1000;
   localparam int DEF_SAT_HOLD = 4;
   localparam int DEF_DC_W     = 16;

endpackage

// File: rtl/sn_sat_cnt.sv
// Up-counter that sticks at MAX and has a synchronous clear taking priority over increment.
// Used for the INIT load count and for the PARITY_OK run length.
module sn_sat_cnt #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = W'(MAX);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sn_decode_ctrl.sv
// Frame sequencer: LOAD channel bits, DECODE until PARITY_OK holds SAT_HOLD cycles or the
// cycle budget runs out, then hold the result until ACK. All outputs are registered.
module sn_decode_ctrl
   import sn_ctrl_pkg::*;
#(
   parameter int INIT_CYC = DEF_INIT_CYC,
   parameter int MAX_DC   = DEF_MAX_DC,
   parameter int SAT_HOLD = DEF_SAT_HOLD,
   parameter int DC_W     = DEF_DC_W
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            START,
   input  logic            ABORT,
   input  logic            PARITY_OK,
   input  logic            ACK,
   output logic            INIT,
   output logic            RUN,
   output logic            LFSR_EN,
   output logic            CNT_CLR,
   output logic            BUSY,
   output logic            DONE,
   output logic            CONV,
   output logic [DC_W-1:0] DC
);

   localparam int LW = $clog2(INIT_CYC + 1);
   localparam int SW = $clog2(SAT_HOLD + 1);
   localparam logic [LW-1:0]   LOAD_LAST = LW'(INIT_CYC - 1);
   localparam logic [SW-1:0]   SAT_LAST  = SW'(SAT_HOLD - 1);
   localparam logic [DC_W-1:0] DC_LAST   = DC_W'(MAX_DC - 1);

   ctrl_state_e     state_q, state_d;
   logic            init_q, init_d;
   logic            run_q, run_d;
   logic            lfsr_en_q, lfsr_en_d;
   logic            cnt_clr_q, cnt_clr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            conv_q, conv_d;
   logic [DC_W-1:0] dc_q, dc_d;

   logic            start_acc;
   logic            conv_next;
   logic            load_inc, sat_clr, sat_inc;
   logic [LW-1:0]   load_cnt;
   logic [SW-1:0]   sat_cnt;

   assign load_inc = (state_q == ST_LOAD);
   assign sat_inc  = (state_q == ST_DECODE) && PARITY_OK;
   assign sat_clr  = start_acc || ((state_q == ST_DECODE) && !PARITY_OK);

   sn_sat_cnt #(.W(LW), .MAX(INIT_CYC)) u_load_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (start_acc),
      .inc   (load_inc),
      .cnt   (load_cnt)
   );

   sn_sat_cnt #(.W(SW), .MAX(SAT_HOLD)) u_sat_cnt (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (sat_clr),
      .inc   (sat_inc),
      .cnt   (sat_cnt)
   );

   always_comb begin
      state_d   = state_q;
      dc_d      = dc_q;
      conv_next = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d   = ST_LOAD;
               dc_d      = '0;
               start_acc = 1'b1;
            end
         end
         ST_LOAD: begin
            if (load_cnt == LOAD_LAST) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            dc_d = dc_q + DC_W'(1);
            // convergence wins when it lands on the same cycle as the budget
            if (PARITY_OK && (sat_cnt == SAT_LAST)) begin
               state_d   = ST_DONE;
               conv_next = 1'b1;
            end else if (dc_q == DC_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            conv_next = conv_q;
            if (ACK) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (ABORT) begin
         state_d   = ST_IDLE;
         dc_d      = '0;
         start_acc = 1'b0;
      end
      // Moore outputs are decoded from the next state so they line up with it
      init_d    = (state_d == ST_LOAD);
      run_d     = (state_d == ST_DECODE);
      lfsr_en_d = (state_d == ST_LOAD) || (state_d == ST_DECODE);
      busy_d    = lfsr_en_d;
      done_d    = (state_d == ST_DONE);
      conv_d    = done_d && conv_next;
      cnt_clr_d = start_acc;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         init_q    <= 1'b0;
         run_q     <= 1'b0;
         lfsr_en_q <= 1'b0;
         cnt_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         conv_q    <= 1'b0;
         dc_q      <= '0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         run_q     <= run_d;
         lfsr_en_q <= lfsr_en_d;
         cnt_clr_q <= cnt_clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         conv_q    <= conv_d;
         dc_q      <= dc_d;
      end
   end

   assign INIT    = init_q;
   assign RUN     = run_q;
   assign LFSR_EN = lfsr_en_q;
   assign CNT_CLR = cnt_clr_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign CONV    = conv_q;
   assign DC      = dc_q;

endmodule

// File: tb/tb_sn_decode_ctrl.sv
// Directed bench for sn_decode_ctrl: a frame table plus hand-written abort/reset/handshake sequences.
// Instance A has a 20-cycle budget, instance B a 10-cycle budget; both see the same inputs.
module tb_sn_decode_ctrl;

   logic CLK = 1'b0;
   logic RST_N, START, ABORT, PARITY_OK, ACK;

   logic a_init, a_run, a_lfsr, a_clr, a_busy, a_done, a_conv;
   logic b_init, b_run, b_lfsr, b_clr, b_busy, b_done, b_conv;
   logic [15:0] a_dc, b_dc;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   sn_decode_ctrl #(.INIT_CYC(8), .MAX_DC(20), .SAT_HOLD(4), .DC_W(16)) u_a (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .PARITY_OK(PARITY_OK), .ACK(ACK),
      .INIT(a_init), .RUN(a_run), .LFSR_EN(a_lfsr), .CNT_CLR(a_clr), .BUSY(a_busy),
      .DONE(a_done), .CONV(a_conv), .DC(a_dc)
   );

   sn_decode_ctrl #(.INIT_CYC(8), .MAX_DC(10), .SAT_HOLD(4), .DC_W(16)) u_b (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .PARITY_OK(PARITY_OK), .ACK(ACK),
      .INIT(b_init), .RUN(b_run), .LFSR_EN(b_lfsr), .CNT_CLR(b_clr), .BUSY(b_busy),
      .DONE(b_done), .CONV(b_conv), .DC(b_dc)
   );

   typedef struct {
      string       name;
      logic [31:0] mask;     // PARITY_OK for decoding cycle k is mask[k-1]
      bit          use_b;
      bit          exp_conv;
      int          exp_dc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_frame();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, ".init"}, a_init, 0);
      chk({tag, ".run"},  a_run,  0);
      chk({tag, ".lfsr"}, a_lfsr, 0);
      chk({tag, ".clr"},  a_clr,  0);
      chk({tag, ".busy"}, a_busy, 0);
      chk({tag, ".done"}, a_done, 0);
      chk({tag, ".conv"}, a_conv, 0);
      chk({tag, ".dc"},   a_dc,   0);
   endtask

   // Runs a frame already started, drives PARITY_OK from mask, acks once both instances are done.
   task automatic run_frame(input vec_t v);
      int  inits = 0, runs = 0, clrs = 0, bad = 0, done_cyc = 0;
      int  dc_at = 0;
      bit  conv_at = 0, run_at = 0, seen = 0, both = 0;
      logic t_init, t_run, t_clr, t_busy, t_done, t_conv;
      logic [15:0] t_dc;
      for (int c = 1; c <= 80 && !both; c++) begin
         t_init = v.use_b ? b_init : a_init;
         t_run  = v.use_b ? b_run  : a_run;
         t_clr  = v.use_b ? b_clr  : a_clr;
         t_busy = v.use_b ? b_busy : a_busy;
         t_done = v.use_b ? b_done : a_done;
         t_conv = v.use_b ? b_conv : a_conv;
         t_dc   = v.use_b ? b_dc   : a_dc;
         if (!seen) begin
            if (t_done) begin
               seen = 1; done_cyc = c; conv_at = t_conv; dc_at = t_dc; run_at = t_run;
            end else begin
               inits += t_init; runs += t_run; clrs += t_clr;
               if ((t_init && t_run) || (t_busy && !t_init && !t_run)) bad++;
            end
         end
         both = a_done && b_done;
         PARITY_OK = (c >= 9 && c - 9 < 32) ? v.mask[c-9] : 1'b0;
         if (!both) tick();
      end
      PARITY_OK = 1'b0;
      chk({v.name, ".done_seen"}, seen, 1);
      chk({v.name, ".conv"}, conv_at, v.exp_conv);
      chk({v.name, ".dc"}, dc_at, v.exp_dc);
      chk({v.name, ".init_cycles"}, inits, 8);
      chk({v.name, ".run_cycles"}, runs, v.exp_dc);
      chk({v.name, ".cnt_clr_cycles"}, clrs, 1);
      chk({v.name, ".init_run_overlap"}, bad, 0);
      chk({v.name, ".run_at_done"}, run_at, 0);
      chk({v.name, ".latency"}, done_cyc, 9 + v.exp_dc);
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      chk({v.name, ".ack_done"}, a_done | b_done, 0);
      chk({v.name, ".ack_conv"}, a_conv | b_conv, 0);
      chk({v.name, ".ack_busy"}, a_busy | b_busy, 0);
      chk({v.name, ".dc_held"}, v.use_b ? b_dc : a_dc, v.exp_dc);
   endtask

   initial begin
      int dones;
      vecs[0] = '{"budget20",   32'h0000_0000, 1'b0, 1'b0, 20};
      vecs[1] = '{"ok_from5",   32'hFFFF_FFF0, 1'b0, 1'b1, 8};
      vecs[2] = '{"ok_toggle",  32'h0000_00F7, 1'b0, 1'b1, 8};
      vecs[3] = '{"coincide",   32'hFFFF_FFC0, 1'b1, 1'b1, 10};
      vecs[4] = '{"ok_from1",   32'hFFFF_FFFF, 1'b0, 1'b1, 4};
      vecs[5] = '{"never_sat",  32'h7777_7777, 1'b0, 1'b0, 20};

      RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; PARITY_OK = 1'b0; ACK = 1'b0;
      repeat (3) tick();
      chk_a_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk_a_zero("idle");

      for (int i = 0; i < 6; i++) begin
         start_frame();
         run_frame(vecs[i]);
         tick();
      end

      // ABORT in LOAD cycle 3
      start_frame();
      tick(); tick();
      chk("abort_load.pre_init", a_init, 1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk_a_zero("abort_load");
      dones = 0;
      repeat (30) begin tick(); dones += a_done; end
      chk("abort_load.no_done", dones, 0);

      // START during DECODE is ignored, then ABORT in DECODE
      start_frame();
      repeat (10) tick();
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("start_in_decode.run", a_run, 1);
      chk("start_in_decode.clr", a_clr, 0);
      chk("start_in_decode.dc", a_dc, 3);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk_a_zero("abort_decode");
      dones = 0;
      repeat (30) begin tick(); dones += a_done; end
      chk("abort_decode.no_done", dones, 0);

      // START together with ACK returns to IDLE without launching a frame
      start_frame();
      PARITY_OK = 1'b1;
      repeat (12) tick();
      chk("startack.pre_done", a_done, 1);
      START = 1'b1; ACK = 1'b1;
      tick();
      START = 1'b0; ACK = 1'b0;
      chk("startack.done", a_done, 0);
      chk("startack.busy", a_busy, 0);
      tick();
      chk("startack.still_idle", a_busy, 0);
      PARITY_OK = 1'b0;
      start_frame();
      chk("startack.restart_init", a_init, 1);
      chk("startack.restart_dc", a_dc, 0);

      // Asynchronous reset mid-DECODE
      repeat (12) tick();
      chk("rst.pre_run", a_run, 1);
      #2 RST_N = 1'b0;
      #1;
      chk_a_zero("rst_async");
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk_a_zero("rst_after");
      start_frame();
      run_frame(vecs[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sn_decode_ctrl.md
# sn_decode_ctrl

Frame-level sequencer for the stochastic equality-node array: on a start request it loads channel probabilities into node edge memories, runs decoding cycles and stops on convergence or cycle budget. It then presents a done/converged result to the host under a ready/ack handshake. It sits between the host interface and the node/check-node fabric, and drives the fabric-wide INIT, run-enable and LFSR step signals.

## Interface
- INIT_CYC, default 8: cycles INIT held high; must be ≥ edge-memory depth (EM_S).
- MAX_DC, default 1000: decoding-cycle budget per frame; range 1..2^DC_W−1.
- SAT_HOLD, default 4: consecutive PARITY_OK cycles required to declare convergence; ≥1.
- DC_W, default 16: width of the decoding-cycle counter.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  frame request; honoured only in IDLE.
- ABORT  in  1  cancel current frame; any state.
- PARITY_OK  in  1  AND of all check-node parity outputs, from the fabric.
- ACK  in  1  host has consumed the result.
- INIT  out  1  to all equality nodes: load channel bit into edge memory.
- RUN  out  1  fabric clock-enable during decoding.
- LFSR_EN  out  1  step the address/selection LFSR.
- CNT_CLR  out  1  one-cycle clear of output-decision up/down counters.
- BUSY  out  1  frame in progress (LOAD or DECODE).
- DONE  out  1  result valid; held until ACK.
- CONV  out  1  qualifier of DONE: 1 = converged, 0 = budget exhausted.
- DC  out  DC_W  decoding cycles used; stable while DONE.

## Operation
- States: IDLE, LOAD, DECODE, DONE. All outputs are registered (Moore); the reset value of every output is 0, with state IDLE.
- IDLE: when START=1, go to LOAD, clear DC, clear the load counter and clear the saturation counter.
- LOAD:
  - INIT=1, LFSR_EN=1, BUSY=1.
  - CNT_CLR=1 on the first LOAD cycle only.
  - The load counter counts to INIT_CYC, then the state moves to DECODE.
- DECODE:
  - RUN=1, LFSR_EN=1, BUSY=1.
  - DC increments by 1 each DECODE cycle.
  - Saturation counter: increments when PARITY_OK=1 (saturating at SAT_HOLD) and clears to 0 when PARITY_OK=0.
  - Exit to DONE with CONV=1 when the saturation counter would reach SAT_HOLD.
  - Otherwise exit to DONE with CONV=0 when DC would reach MAX_DC.
  - If both exit conditions hit in the same cycle, CONV=1.
- DONE: DONE=1, CONV and DC frozen. ACK=1 returns to IDLE and clears DONE and CONV; DC holds its value until the next START.
- ABORT:
  - Highest priority: from any state, the next state is IDLE with INIT, RUN, LFSR_EN, BUSY and DONE all 0.
  - DONE is never raised for an aborted frame.
- START outside IDLE is ignored, including START together with ACK in DONE: return to IDLE, and a new START is needed.
- Asynchronous reset mid-frame forces IDLE and all outputs 0 immediately; no partial result is reported.

## Timing
- START sampled at edge t → INIT high for cycles t+1 … t+INIT_CYC.
- RUN high from t+INIT_CYC+1.
- INIT and RUN are never high in the same cycle, and never both low while BUSY=1.
- PARITY_OK is sampled on the same edge that advances DC. Convergence after the k-th decoding cycle (with SAT_HOLD consecutive OKs ending at k) gives DC=k, DONE=1 on the next cycle and RUN=0 in that same cycle.
- Budget exhaustion: RUN is high for exactly MAX_DC cycles; DONE=1 with DC=MAX_DC.
- DC never wraps, since MAX_DC < 2^DC_W by parameter rule.
- Minimum frame latency, START to DONE: 1 + INIT_CYC + SAT_HOLD cycles.
- ACK → IDLE next cycle; the earliest next START is accepted in the cycle after that.

## Structure
- Shared package sn_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD, DECODE, DONE);
  - default constants INIT_CYC, MAX_DC and SAT_HOLD, reused by the node array top.
- One sub-module, sn_sat_cnt: a generic saturating counter with clear. It is instantiated twice: for the load count, and for the PARITY_OK run length.
- The DC counter and the FSM stay inline.

## Test plan
- Reset then START=1 for one cycle with PARITY_OK=0 and MAX_DC=20 → INIT high for exactly 8 cycles, RUN high for 20, then DONE=1, CONV=0, DC=20; ACK → IDLE.
- PARITY_OK=1 from decoding cycle 5 onward, SAT_HOLD=4 → DONE, CONV=1, DC=8; RUN low from the DONE cycle.
- PARITY_OK toggles 1,1,1,0,1,1,1,1 → the saturation counter restarts after the 0; converges with DC=8.
- Convergence and budget coincide (MAX_DC=10, PARITY_OK high from cycle 7) → CONV=1, DC=10.
- ABORT during LOAD cycle 3, and separately during DECODE → next cycle IDLE, all outputs 0, no DONE. START during DECODE has no effect.
- RST_N pulsed low mid-DECODE → outputs 0 asynchronously. Afterwards START runs a full clean frame with DC starting from 0.
